hazard_pool_controller: RTL and testbench

//  Per-frame liquid-hazard checker for up to NUM_POOLS runtime-loadable pools (lava/water/goo).

---
 rtl/hazard_pool_controller.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_pool_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pool_controller.sv
// Per-frame liquid-hazard checker: snapshots both player boxes on frame_tick,
// scans one pool slot per clock, and latches deaths after a run of lethal frames.
module hazard_pool_controller #(
  parameter int NUM_POOLS    = 3,
  parameter int IDX_W        = 2,
  parameter int COORD_W      = 16,
  parameter int POOL_W       = 74,
  parameter int POOL_H       = 5,
  parameter int DWELL_FRAMES = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_tick,
  input  logic                      clear_deaths,
  input  logic signed [COORD_W-1:0] p1_top,
  input  logic signed [COORD_W-1:0] p1_bottom,
  input  logic signed [COORD_W-1:0] p1_left,
  input  logic signed [COORD_W-1:0] p1_right,
  input  logic signed [COORD_W-1:0] p2_top,
  input  logic signed [COORD_W-1:0] p2_bottom,
  input  logic signed [COORD_W-1:0] p2_left,
  input  logic signed [COORD_W-1:0] p2_right,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic signed [COORD_W-1:0] cfg_x,
  input  logic signed [COORD_W-1:0] cfg_y,
  input  logic [1:0]                cfg_type,
  input  logic                      cfg_en,
  output logic                      cfg_ready,
  output logic                      player1_dead,
  output logic                      player2_dead,
  output logic [IDX_W-1:0]          p1_cause_idx,
  output logic [IDX_W-1:0]          p2_cause_idx,
  output logic [1:0]                p1_cause_type,
  output logic [1:0]                p2_cause_type,
  output logic                      scan_busy,
  output logic                      frame_done,
  output logic                      overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVAL} state_t;
  typedef enum logic [1:0] {LAVA = 2'd0, WATER = 2'd1, GOO = 2'd2, INERT = 2'd3} pool_t;

  localparam int CNT_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [CNT_W-1:0]        DWELL  = CNT_W'(DWELL_FRAMES);
  localparam logic [IDX_W-1:0]        LAST   = IDX_W'(NUM_POOLS - 1);
  localparam logic signed [COORD_W:0] PW_EXT = (COORD_W + 1)'(POOL_W);
  localparam logic signed [COORD_W:0] PH_EXT = (COORD_W + 1)'(POOL_H);

  state_t                    state_q, state_d;
  logic                      pen_q [NUM_POOLS];
  logic signed [COORD_W-1:0] px_q  [NUM_POOLS];
  logic signed [COORD_W-1:0] py_q  [NUM_POOLS];
  pool_t                     pt_q  [NUM_POOLS];

  logic signed [COORD_W-1:0] s1_t_q, s1_b_q, s1_l_q, s1_r_q;
  logic signed [COORD_W-1:0] s2_t_q, s2_b_q, s2_l_q, s2_r_q;
  logic [IDX_W-1:0]          i_q;
  logic                      hit1_q, hit2_q;
  logic [IDX_W-1:0]          hidx1_q, hidx2_q, cidx1_q, cidx2_q;
  pool_t                     htype1_q, htype2_q, ctype1_q, ctype2_q;
  logic [CNT_W-1:0]          cnt1_q, cnt2_q, cnt1_inc, cnt2_inc;
  logic                      dead1_q, dead2_q, fd_q, ovr_q;
  logic                      slot_p1_hit, slot_p2_hit;
  pool_t                     cur_t;

  function automatic logic signed [COORD_W:0] ext(input logic signed [COORD_W-1:0] v);
    return $signed({v[COORD_W-1], v});
  endfunction

  function automatic logic overlap(input logic signed [COORD_W-1:0] l, r, t, b, x, y);
    return (ext(r) > ext(x)) && (ext(l) < ext(x) + PW_EXT) &&
           (ext(b) > ext(y)) && (ext(t) < ext(y) + PH_EXT);
  endfunction

  always_comb begin
    cur_t       = pt_q[i_q];
    slot_p1_hit = pen_q[i_q] && (cur_t == WATER || cur_t == GOO) &&
                  overlap(s1_l_q, s1_r_q, s1_t_q, s1_b_q, px_q[i_q], py_q[i_q]);
    slot_p2_hit = pen_q[i_q] && (cur_t == LAVA || cur_t == GOO) &&
                  overlap(s2_l_q, s2_r_q, s2_t_q, s2_b_q, px_q[i_q], py_q[i_q]);
    cnt1_inc    = (cnt1_q == DWELL) ? cnt1_q : cnt1_q + 1'b1;
    cnt2_inc    = (cnt2_q == DWELL) ? cnt2_q : cnt2_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_tick) state_d = S_SCAN;
      S_SCAN:  if (i_q == LAST) state_d = S_EVAL;
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_deaths) state_d = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_POOLS; k++) begin
        pen_q[k] <= 1'b0;
        px_q[k]  <= '0;
        py_q[k]  <= '0;
        pt_q[k]  <= INERT;
      end
      {s1_t_q, s1_b_q, s1_l_q, s1_r_q} <= '0;
      {s2_t_q, s2_b_q, s2_l_q, s2_r_q} <= '0;
      i_q      <= '0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      hidx1_q  <= '0;
      hidx2_q  <= '0;
      htype1_q <= INERT;
      htype2_q <= INERT;
      cidx1_q  <= '0;
      cidx2_q  <= '0;
      ctype1_q <= LAVA;
      ctype2_q <= LAVA;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      dead1_q  <= 1'b0;
      dead2_q  <= 1'b0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (cfg_we && state_q == S_IDLE && int'(cfg_idx) < NUM_POOLS) begin
        pen_q[cfg_idx] <= cfg_en;
        px_q[cfg_idx]  <= cfg_x;
        py_q[cfg_idx]  <= cfg_y;
        pt_q[cfg_idx]  <= pool_t'(cfg_type);
      end
      if (clear_deaths) begin
        cidx1_q  <= '0;
        cidx2_q  <= '0;
        ctype1_q <= LAVA;
        ctype2_q <= LAVA;
        cnt1_q   <= '0;
        cnt2_q   <= '0;
        dead1_q  <= 1'b0;
        dead2_q  <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (frame_tick && state_q != S_IDLE) ovr_q <= 1'b1;
        case (state_q)
          S_IDLE: if (frame_tick) begin
            {s1_t_q, s1_b_q, s1_l_q, s1_r_q} <= {p1_top, p1_bottom, p1_left, p1_right};
            {s2_t_q, s2_b_q, s2_l_q, s2_r_q} <= {p2_top, p2_bottom, p2_left, p2_right};
            i_q    <= '0;
            hit1_q <= 1'b0;
            hit2_q <= 1'b0;
          end
          S_SCAN: begin
            i_q <= i_q + 1'b1;
            // Ascending scan: only the first lethal slot is recorded as the cause.
            if (slot_p1_hit && !hit1_q) begin
              hit1_q   <= 1'b1;
              hidx1_q  <= i_q;
              htype1_q <= cur_t;
            end
            if (slot_p2_hit && !hit2_q) begin
              hit2_q   <= 1'b1;
              hidx2_q  <= i_q;
              htype2_q <= cur_t;
            end
          end
          S_EVAL: begin
            fd_q <= 1'b1;
            if (!dead1_q) begin
              if (hit1_q) begin
                cnt1_q <= cnt1_inc;
                if (cnt1_inc == DWELL) begin
                  dead1_q  <= 1'b1;
                  cidx1_q  <= hidx1_q;
                  ctype1_q <= htype1_q;
                end
              end else cnt1_q <= '0;
            end
            if (!dead2_q) begin
              if (hit2_q) begin
                cnt2_q <= cnt2_inc;
                if (cnt2_inc == DWELL) begin
                  dead2_q  <= 1'b1;
                  cidx2_q  <= hidx2_q;
                  ctype2_q <= htype2_q;
                end
              end else cnt2_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg_ready     = (state_q == S_IDLE);
  assign scan_busy     = (state_q != S_IDLE);
  assign player1_dead  = dead1_q;
  assign player2_dead  = dead2_q;
  assign p1_cause_idx  = cidx1_q;
  assign p2_cause_idx  = cidx2_q;
  assign p1_cause_type = ctype1_q;
  assign p2_cause_type = ctype2_q;
  assign frame_done    = fd_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_hazard_pool_controller.sv
// Bench for hazard_pool_controller: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed outcomes.
module tb_hazard_pool_controller;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int PW = 74;
  localparam int PH = 5;
  localparam int DW = 2;

  logic Clk = 1'b0;
  logic Reset, frame_tick, clear_deaths, cfg_we, cfg_en;
  logic signed [CW-1:0] p1_top, p1_bottom, p1_left, p1_right;
  logic signed [CW-1:0] p2_top, p2_bottom, p2_left, p2_right;
  logic signed [CW-1:0] cfg_x, cfg_y;
  logic [IW-1:0] cfg_idx;
  logic [1:0] cfg_type;
  logic cfg_ready, player1_dead, player2_dead, scan_busy, frame_done, overrun;
  logic [IW-1:0] p1_cause_idx, p2_cause_idx;
  logic [1:0] p1_cause_type, p2_cause_type;

  hazard_pool_controller #(
    .NUM_POOLS(N), .IDX_W(IW), .COORD_W(CW), .POOL_W(PW), .POOL_H(PH), .DWELL_FRAMES(DW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .clear_deaths(clear_deaths),
    .p1_top(p1_top), .p1_bottom(p1_bottom), .p1_left(p1_left), .p1_right(p1_right),
    .p2_top(p2_top), .p2_bottom(p2_bottom), .p2_left(p2_left), .p2_right(p2_right),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_type(cfg_type), .cfg_en(cfg_en), .cfg_ready(cfg_ready),
    .player1_dead(player1_dead), .player2_dead(player2_dead),
    .p1_cause_idx(p1_cause_idx), .p2_cause_idx(p2_cause_idx),
    .p1_cause_type(p1_cause_type), .p2_cause_type(p2_cause_type),
    .scan_busy(scan_busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: frame-granular, one result computed per accepted tick
  int  px [N], py [N], pt [N], pen [N];
  int  m_ph, m_cnt1, m_cnt2, m_dead1, m_dead2, m_ci1, m_ct1, m_ci2, m_ct2, m_ovr, m_fd;
  int  h1, h2, ht1, ht2;
  bit  mon_on = 1'b0;

  function automatic bit lethal(input int who, input int t);
    return (t == 2) || (who == 1 && t == 1) || (who == 2 && t == 0);
  endfunction

  function automatic int first_hit(input int who, input int l, input int r, input int t, input int b);
    for (int i = 0; i < N; i++)
      if (pen[i] != 0 && lethal(who, pt[i]) && r > px[i] && l < px[i] + PW &&
          b > py[i] && t < py[i] + PH)
        return i;
    return -1;
  endfunction

  always @(posedge Clk) begin : model
    m_fd = 0;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin pen[i] = 0; px[i] = 0; py[i] = 0; pt[i] = 3; end
      m_ph = 0; m_cnt1 = 0; m_cnt2 = 0; m_dead1 = 0; m_dead2 = 0;
      m_ci1 = 0; m_ct1 = 0; m_ci2 = 0; m_ct2 = 0; m_ovr = 0;
    end else begin
      if (m_ph == 0 && cfg_we && int'(cfg_idx) < N) begin
        pen[cfg_idx] = int'(cfg_en); px[cfg_idx] = int'(cfg_x);
        py[cfg_idx] = int'(cfg_y);   pt[cfg_idx] = int'(cfg_type);
      end
      if (clear_deaths) begin
        m_ph = 0; m_cnt1 = 0; m_cnt2 = 0; m_dead1 = 0; m_dead2 = 0;
        m_ci1 = 0; m_ct1 = 0; m_ci2 = 0; m_ct2 = 0; m_ovr = 0;
      end else if (m_ph == 0) begin
        if (frame_tick) begin
          h1 = first_hit(1, int'(p1_left), int'(p1_right), int'(p1_top), int'(p1_bottom));
          h2 = first_hit(2, int'(p2_left), int'(p2_right), int'(p2_top), int'(p2_bottom));
          ht1 = (h1 >= 0) ? pt[h1] : 0;
          ht2 = (h2 >= 0) ? pt[h2] : 0;
          m_ph = 1;
        end
      end else begin
        if (frame_tick) m_ovr = 1;
        if (m_ph == N + 1) begin
          m_fd = 1; m_ph = 0;
          if (m_dead1 == 0) begin
            m_cnt1 = (h1 >= 0) ? ((m_cnt1 + 1 > DW) ? DW : m_cnt1 + 1) : 0;
            if (m_cnt1 == DW) begin m_dead1 = 1; m_ci1 = h1; m_ct1 = ht1; end
          end
          if (m_dead2 == 0) begin
            m_cnt2 = (h2 >= 0) ? ((m_cnt2 + 1 > DW) ? DW : m_cnt2 + 1) : 0;
            if (m_cnt2 == DW) begin m_dead2 = 1; m_ci2 = h2; m_ct2 = ht2; end
          end
        end else m_ph++;
      end
    end
  end

  always @(negedge Clk) begin : compare
    if (mon_on) begin
      chk("cfg_ready",  cfg_ready,     (m_ph == 0) ? 1 : 0);
      chk("scan_busy",  scan_busy,     (m_ph != 0) ? 1 : 0);
      chk("frame_done", frame_done,    m_fd);
      chk("overrun",    overrun,       m_ovr);
      chk("p1_dead",    player1_dead,  m_dead1);
      chk("p2_dead",    player2_dead,  m_dead2);
      chk("p1_cidx",    p1_cause_idx,  m_ci1);
      chk("p1_ctype",   p1_cause_type, m_ct1);
      chk("p2_cidx",    p2_cause_idx,  m_ci2);
      chk("p2_ctype",   p2_cause_type, m_ct2);
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic cfg(input int idx, input int x, input int y, input int t, input int en);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 16'(x); cfg_y = 16'(y);
    cfg_type = 2'(t); cfg_en = 1'(en);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_p1(input int l, input int r, input int t, input int b);
    p1_left = 16'(l); p1_right = 16'(r); p1_top = 16'(t); p1_bottom = 16'(b);
  endtask

  task automatic set_p2(input int l, input int r, input int t, input int b);
    p2_left = 16'(l); p2_right = 16'(r); p2_top = 16'(t); p2_bottom = 16'(b);
  endtask

  task automatic frame();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (N + 1) step();
  endtask

  task automatic clr();
    clear_deaths = 1'b1; step(); clear_deaths = 1'b0;
  endtask

  task automatic load_pools();
    cfg(0, 302, 463, 0, 1);
    cfg(1, 430, 463, 1, 1);
    cfg(2, 398, 363, 2, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, fds;
    bit found;
    Reset = 1'b1; frame_tick = 1'b0; clear_deaths = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_type = '0; cfg_en = 1'b0;
    set_p1(0, 10, 0, 10); set_p2(0, 10, 0, 10);
    step(); step();
    mon_on = 1'b1;
    Reset = 1'b0;
    step();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", scan_busy, 0);
    chk("rst_dead", {player1_dead, player2_dead, overrun, frame_done}, 0);

    load_pools();
    cfg(3, 100, 100, 2, 1);  // out-of-range slot, must be ignored

    // P1 over lava: immune
    set_p1(310, 330, 440, 465);
    repeat (3) frame();
    chk("p1_lava_immune", player1_dead, 0);

    // Same box on P2: dies on the second frame, cause pool 0 lava
    set_p1(0, 10, 0, 10); set_p2(310, 330, 440, 465);
    frame();
    chk("p2_lava_f1", player2_dead, 0);
    frame();
    chk("p2_lava_f2", player2_dead, 1);
    chk("p2_lava_idx", p2_cause_idx, 0);
    chk("p2_lava_type", p2_cause_type, 0);

    // Touching edge is not overlap; one pixel in is
    clr();
    set_p2(250, 302, 440, 465);
    repeat (4) frame();
    chk("edge_touch", player2_dead, 0);
    set_p2(250, 303, 440, 465);
    repeat (2) frame();
    chk("edge_in", player2_dead, 1);

    // Interrupted exposure resets the dwell counter
    clr(); set_p2(0, 10, 0, 10);
    set_p1(400, 410, 360, 366); frame();
    set_p1(0, 10, 0, 10);       frame();
    set_p1(400, 410, 360, 366); frame();
    chk("dwell_reset", player1_dead, 0);

    // Both in goo die together
    clr();
    set_p1(400, 410, 360, 366); set_p2(400, 410, 360, 366);
    frame();
    chk("goo_f1", {player1_dead, player2_dead}, 0);
    frame();
    chk("goo_both", {player1_dead, player2_dead}, 3);
    chk("goo_idx", {p1_cause_idx, p2_cause_idx}, 4'b1010);
    chk("goo_type", {p1_cause_type, p2_cause_type}, 4'b1010);

    // Water and goo both lethal to P1: lower index wins
    clr(); set_p2(0, 10, 0, 10);
    set_p1(440, 450, 360, 470);
    repeat (2) frame();
    chk("multi_dead", player1_dead, 1);
    chk("multi_idx", p1_cause_idx, 1);
    chk("multi_type", p1_cause_type, 1);

    // Latency from tick to frame_done
    clr(); set_p1(0, 10, 0, 10);
    frame_tick = 1'b1; n = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(); frame_tick = 1'b0; n++;
      if (frame_done) found = 1'b1;
    end
    chk("latency", n, N + 2);
    step();

    // Tick while busy: overrun, single frame_done
    frame_tick = 1'b1; step(); step(); frame_tick = 1'b0;
    fds = 0;
    for (int k = 0; k < 10; k++) begin step(); if (frame_done) fds++; end
    chk("overrun_flag", overrun, 1);
    chk("overrun_fd", fds, 1);

    // clear_deaths mid-scan aborts the frame and clears the dwell count
    clr(); set_p2(310, 330, 440, 465);
    frame();
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    clr();
    fds = 0;
    for (int k = 0; k < 8; k++) begin step(); if (frame_done) fds++; end
    chk("clr_no_fd", fds, 0);
    chk("clr_state", {scan_busy, player2_dead, overrun}, 0);
    frame();
    chk("clr_cnt", player2_dead, 0);

    // clear_deaths beats a same-cycle tick
    clear_deaths = 1'b1; frame_tick = 1'b1; step();
    clear_deaths = 1'b0; frame_tick = 1'b0;
    chk("clr_tick", {scan_busy, overrun}, 0);

    // Write during scan is dropped
    clr();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    cfg(0, 302, 463, 3, 0);
    repeat (N) step();
    frame();
    chk("cfg_busy_drop", player2_dead, 1);
    chk("cfg_busy_idx", p2_cause_idx, 0);

    // Write with the tick in idle is used by that scan
    clr();
    frame();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 16'sd302; cfg_y = 16'sd463;
    cfg_type = 2'd0; cfg_en = 1'b0; frame_tick = 1'b1;
    step();
    cfg_we = 1'b0; frame_tick = 1'b0;
    repeat (N + 1) step();
    chk("cfg_tick_apply", player2_dead, 0);
    load_pools();

    // Reset mid-scan restores reset values and disables slots
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("rst2_ready", {cfg_ready, scan_busy}, 2'b10);
    chk("rst2_flags", {player1_dead, player2_dead, overrun, frame_done}, 0);
    repeat (2) frame();
    chk("rst2_slots", player2_dead, 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
